// File: rtl/wb_grf.sv
// Write-back stage: M/W pipeline latch feeding a 32x32 general register file
// with two bypassed combinational read ports and a committed-write counter.
module wb_grf #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          WB_CNT_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic                m_we,
  input  logic [4:0]          m_waddr,
  input  logic [31:0]         m_wdata,
  input  logic [31:0]         m_pc,
  input  logic [4:0]          ra1,
  input  logic [4:0]          ra2,
  output logic [31:0]         rd1,
  output logic [31:0]         rd2,
  output logic                w_we,
  output logic [4:0]          w_waddr,
  output logic [31:0]         w_wdata,
  output logic [31:0]         w_pc,
  output logic                wb_commit,
  output logic [WB_CNT_W-1:0] wb_count
);

  logic        committed;
  logic [31:0] grf [32];
  logic        pending;

  // A held latch may commit only once; committed clears whenever the latch reloads.
  assign wb_commit = w_we && (w_waddr != 5'd0) && !committed;
  assign pending   = w_we && !committed;

  function automatic logic [31:0] read_port(
    input logic [4:0]  ra,
    input logic        pend,
    input logic [4:0]  waddr,
    input logic [31:0] wdata,
    input logic [31:0] arr_val
  );
    if (ra == 5'd0)                  return 32'd0;
    else if (pend && (waddr == ra))  return wdata;
    else                             return arr_val;
  endfunction

  assign rd1 = read_port(ra1, pending, w_waddr, w_wdata, grf[ra1]);
  assign rd2 = read_port(ra2, pending, w_waddr, w_wdata, grf[ra2]);

  // W latch, commit bookkeeping and counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_we      <= 1'b0;
      w_waddr   <= 5'd0;
      w_wdata   <= 32'd0;
      w_pc      <= PC_RESET;
      committed <= 1'b0;
      wb_count  <= '0;
    end else begin
      if (clr) begin
        w_we    <= 1'b0;
        w_waddr <= 5'd0;
        w_wdata <= 32'd0;
        w_pc    <= PC_RESET;
      end else if (en) begin
        w_we    <= m_we;
        w_waddr <= m_waddr;
        w_wdata <= m_wdata;
        w_pc    <= m_pc;
      end
      if (clr || en)
        committed <= 1'b0;
      else if (wb_commit)
        committed <= 1'b1;
      if (wb_commit)
        wb_count <= wb_count + {{(WB_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Register array; the write uses the latch contents before this edge's capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++)
        grf[i] <= 32'd0;
    end else if (wb_commit) begin
      grf[w_waddr] <= w_wdata;
    end
  end

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: directed scenarios plus randomized traffic checked against
// a behavioural model of the write-back stage and register file.
module tb_wb_grf;

  logic        clk = 1'b0;
  logic        reset;
  logic        en, clr, m_we;
  logic [4:0]  m_waddr, ra1, ra2;
  logic [31:0] m_wdata, m_pc;
  logic [31:0] rd1, rd2, w_wdata, w_pc;
  logic        w_we, wb_commit;
  logic [4:0]  w_waddr;
  logic [3:0]  wb_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  wb_grf #(.PC_RESET(32'h0000_3000), .WB_CNT_W(4)) dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .m_we(m_we),
    .m_waddr(m_waddr), .m_wdata(m_wdata), .m_pc(m_pc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .w_we(w_we), .w_waddr(w_waddr), .w_wdata(w_wdata), .w_pc(w_pc),
    .wb_commit(wb_commit), .wb_count(wb_count)
  );

  // Reference model: architectural register values, the instruction sitting in W,
  // and whether that instruction has already written back.
  logic [31:0] regs [32];
  logic        i_we;
  logic [4:0]  i_rd;
  logic [31:0] i_val, i_pc;
  bit          i_written;
  logic [3:0]  n_writes;

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 0) return 32'd0;
    if (i_we && !i_written && i_rd == a) return i_val;
    return regs[a];
  endfunction

  function automatic bit ref_will_write();
    return i_we && i_rd != 0 && !i_written;
  endfunction

  task automatic ref_reset();
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    i_we = 0; i_rd = 0; i_val = 0; i_pc = 32'h3000; i_written = 0; n_writes = 0;
  endtask

  task automatic ref_clock();
    bit wr;
    wr = ref_will_write();
    if (wr) begin
      regs[i_rd] = i_val;
      n_writes   = n_writes + 4'd1;
    end
    if (clr) begin
      i_we = 0; i_rd = 0; i_val = 0; i_pc = 32'h3000; i_written = 0;
    end else if (en) begin
      i_we = m_we; i_rd = m_waddr; i_val = m_wdata; i_pc = m_pc; i_written = 0;
    end else if (wr) begin
      i_written = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("w_we",      {31'd0, w_we},      {31'd0, i_we});
    chk("w_waddr",   {27'd0, w_waddr},   {27'd0, i_rd});
    chk("w_wdata",   w_wdata,            i_val);
    chk("w_pc",      w_pc,               i_pc);
    chk("wb_commit", {31'd0, wb_commit}, {31'd0, ref_will_write()});
    chk("wb_count",  {28'd0, wb_count},  {28'd0, n_writes});
    chk("rd1",       rd1,                ref_read(ra1));
    chk("rd2",       rd2,                ref_read(ra2));
  endtask

  // One clock cycle: apply inputs, check settled outputs, then take the edge.
  task automatic cyc(input logic e, input logic c, input logic we, input logic [4:0] a,
                     input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    en = e; clr = c; m_we = we; m_waddr = a; m_wdata = d; m_pc = $urandom;
    ra1 = r1; ra2 = r2;
    #1;
    check_all();
    @(posedge clk);
    if (reset) ref_clock(); else ref_reset();
    #1;
  endtask

  task automatic sweep_reads();
    for (int a = 0; a < 32; a++) begin
      ra1 = a[4:0]; ra2 = 5'(31 - a);
      #1;
      chk("sweep_rd1", rd1, ref_read(ra1));
      chk("sweep_rd2", rd2, ref_read(ra2));
    end
  endtask

  initial begin
    reset = 1'b0;
    ref_reset();
    en = 0; clr = 0; m_we = 0; m_waddr = 0; m_wdata = 0; m_pc = 0; ra1 = 0; ra2 = 0;
    @(posedge clk); #1;

    // Reset held with random inputs
    for (int i = 0; i < 4; i++)
      cyc($urandom, $urandom, 1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
    chk("rst_w_pc", w_pc, 32'h0000_3000);
    chk("rst_count", {28'd0, wb_count}, 32'd0);
    sweep_reads();
    #2 reset = 1'b1;
    @(negedge clk); #1;

    // Basic write with bypass, then array read
    cyc(1, 0, 1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
    cyc(0, 0, 0, 5'd0, 32'd0, 5'd5, 5'd5);
    chk("basic_bypass_prev", 32'(n_writes), 32'd1);
    cyc(0, 0, 0, 5'd0, 32'd0, 5'd5, 5'd5);
    chk("basic_array", rd1, 32'hDEADBEEF);
    chk("basic_count", {28'd0, wb_count}, 32'd1);

    // $0 guard
    cyc(1, 0, 1, 5'd0, 32'h1234, 5'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
      chk("zero_commit", {31'd0, wb_commit}, 32'd0);
      chk("zero_rd1", rd1, 32'd0);
    end
    chk("zero_count", {28'd0, wb_count}, 32'd1);

    // Held latch commits once
    cyc(1, 0, 1, 5'd8, 32'd7, 5'd8, 5'd8);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 0, 5'd0, 32'd0, 5'd8, 5'd8);
      chk("hold_rd1", rd1, 32'd7);
    end
    chk("hold_count", {28'd0, wb_count}, 32'd2);

    // Flush on the same edge as a commit
    cyc(1, 0, 1, 5'd3, 32'd9, 5'd3, 5'd4);
    cyc(1, 1, 1, 5'd4, 32'd1, 5'd3, 5'd4);
    chk("flush_we", {31'd0, w_we}, 32'd0);
    cyc(1, 0, 0, 5'd0, 32'd0, 5'd3, 5'd4);
    chk("flush_rd3", rd1, 32'd9);
    chk("flush_rd4", rd2, 32'd0);
    chk("flush_count", {28'd0, wb_count}, 32'd3);

    // Async reset drops a pending write
    cyc(1, 0, 1, 5'd10, 32'd5, 5'd10, 5'd10);
    en = 0; clr = 0; m_we = 0;
    #2 reset = 1'b0;
    ref_reset();
    #1;
    chk("arst_w_we", {31'd0, w_we}, 32'd0);
    chk("arst_w_pc", w_pc, 32'h0000_3000);
    chk("arst_count", {28'd0, wb_count}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    cyc(0, 0, 0, 5'd0, 32'd0, 5'd10, 5'd10);
    chk("arst_rd10", rd1, 32'd0);

    // Counter wrap: 15 commits then one more
    for (int i = 0; i < 15; i++)
      cyc(1, 0, 1, 5'(1 + i), $urandom, 5'(1 + i), 5'(i));
    cyc(0, 0, 0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("wrap_full", {28'd0, wb_count}, 32'd15);
    cyc(1, 0, 1, 5'd20, 32'hA5A5_0001, 5'd20, 5'd0);
    cyc(0, 0, 0, 5'd0, 32'd0, 5'd20, 5'd0);
    chk("wrap_zero", {28'd0, wb_count}, 32'd0);
    chk("wrap_rd20", rd1, 32'hA5A5_0001);

    // Randomized traffic on a narrow address range to force collisions
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) != 0, ($urandom % 8) == 0, $urandom, 5'($urandom % 8),
          $urandom, 5'($urandom % 8), 5'($urandom % 8));
    sweep_reads();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_grf.md
Name: wb_grf

Overview:
- Write-back stage of the 5-stage MIPS pipeline: the M/W pipeline register plus the general register file (GRF).
- Consumes the gated register write enable produced upstream in M (already suppressed for nop encodings), with write address, write data and PC.
- Latches these into the W stage and commits them to the 32x32 GRF on the following edge.
- Provides two combinational read ports with W-stage bypass, and exports W-stage state for hazard/forwarding logic.

Parameters:
- PC_RESET, 32'h0000_3000, reset value of w_pc (text segment base).
- WB_CNT_W, 32, width of the committed-write counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- en  input  1  W-stage advance; 1 = capture M-stage inputs at posedge.
- clr  input  1  synchronous flush; W latch becomes a bubble at posedge.
- m_we  input  1  gated register write enable from M stage.
- m_waddr  input  5  destination register from M stage.
- m_wdata  input  32  write-back data from M stage.
- m_pc  input  32  PC of the M-stage instruction.
- ra1  input  5  read address, port 1.
- ra2  input  5  read address, port 2.
- rd1  output  32  read data, port 1 (combinational).
- rd2  output  32  read data, port 2 (combinational).
- w_we  output  1  W latch write enable (raw latched value).
- w_waddr  output  5  W latch destination register.
- w_wdata  output  32  W latch data.
- w_pc  output  32  W latch PC.
- wb_commit  output  1  1 in any cycle where a GRF write is performed at the next posedge.
- wb_count  output  WB_CNT_W  number of committed GRF writes, modulo 2^WB_CNT_W.

Behaviour:
- Reset (reset=0, asynchronous, dominates everything):
  - w_we=0, w_waddr=0, w_wdata=0, w_pc=PC_RESET.
  - All 32 GRF entries = 0; wb_count=0; internal committed flag = 0.
  - Outputs take these values immediately, not at the next clock edge.
- W latch update at posedge, priority clr > en > hold:
  - clr=1: latch <= bubble (we=0, waddr=0, wdata=0, pc=PC_RESET), regardless of en.
  - en=1: latch <= {m_we, m_waddr, m_wdata, m_pc}.
  - else: latch holds its value.
- Commit condition: wb_commit = w_we && (w_waddr != 0) && !committed.
- When wb_commit=1, at posedge: GRF[w_waddr] <= w_wdata, and wb_count increments by 1, wrapping to 0 after the all-ones value.
- committed flag prevents a held latch from double-committing:
  - At posedge: if latch reloads (en=1 or clr=1), committed <= 0.
  - Else if wb_commit=1, committed <= 1.
  - A held instruction writes and counts exactly once.
- Latency: M-stage values are visible on w_* one cycle after capture and are written to the GRF at the posedge after that. They are readable from the array two edges after capture, and via bypass from the cycle after capture.
- Read ports, purely combinational, for each port i:
  - rai == 0 -> rdi = 0.
  - Else if w_we && w_waddr == rai && !committed -> rdi = w_wdata (bypass of the pending write).
  - Else rdi = GRF[rai].
- $0 is hardwired:
  - Writes to address 0 are never performed and never counted, even if w_we=1.
  - GRF[0] always reads 0.
- Simultaneous events:
  - Commit of the current latch and capture of a new latch occur on the same edge. The array write uses the old latch contents.
  - clr on a cycle where wb_commit=1: the old write still commits on that edge (commit depends only on the current latch); the new latch is a bubble.
  - Back-to-back writes to the same register: the later one wins. Bypass always reflects the current latch.
- Reset mid-operation: a pending uncommitted write is discarded and not counted.
- w_we is exported raw. Forwarding logic must itself qualify it with w_waddr != 0.

Test Plan:
- Reset release: hold reset=0 with random inputs -> w_pc=32'h3000, w_we=0, rd1=rd2=0 for all addresses, wb_count=0.
- Basic write: en=1, m_we=1, m_waddr=5, m_wdata=32'hDEADBEEF for one cycle, ra1=5 -> rd1=DEADBEEF via bypass the cycle after capture, and from the array afterwards. wb_count=1.
- $0 guard: capture m_we=1, m_waddr=0, m_wdata=32'h1234 -> wb_commit never 1, rd1 with ra1=0 stays 0, wb_count unchanged.
- Hold without double count: capture a write to $8=7, then en=0 for 5 cycles -> exactly one commit, wb_count +1, rd1(8)=7 throughout.
- Flush with simultaneous commit: latch holds a write to $3=9, then assert clr=1 and en=1 with M-stage write to $4=1 on the same edge -> $3=9 is committed, latch becomes a bubble, $4 is never written, wb_count +1.
- Async reset mid-op: capture a write to $10=5 and drop reset to 0 before the commit edge -> $10 reads 0 after reset release, wb_count=0. Also force wb_count to all-ones via writes and commit once more -> wraps to 0.
